// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode/execute skid stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the occupancy state enum, the RISC-V NOP encoding used to build
// the bubble payload, and a small helper that maps state to entry count.
package pipe_pkg;

    // Occupancy of the two-entry stage. Encoding equals the entry count so
    // the level output is a straight copy, but the helper below keeps the
    // mapping explicit should the encoding ever change.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // addi x0, x0, 0 : canonical RISC-V NOP, inserted as the bubble instruction.
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    localparam int PC_W       = 64;
    localparam int INSN_W     = 32;
    localparam int DEF_PAY_W  = PC_W + INSN_W;

    // Default bubble: PC of zero with a NOP instruction.
    localparam logic [DEF_PAY_W-1:0] DEF_BUBBLE = {{PC_W{1'b0}}, RV_NOP};

    // Number of held entries for a given state.
    function automatic logic [1:0] state_level(input state_e st);
        logic [1:0] lvl;
        case (st)
            EMPTY:   lvl = 2'd0;
            ONE:     lvl = 2'd1;
            TWO:     lvl = 2'd2;
            default: lvl = 2'd0;
        endcase
        return lvl;
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_skid_stage.sv
// Two-entry registered skid stage between pipeline stages (MAIN + SKID).
// Latency: 1 cycle in-to-out; full throughput with out_ready held high.
// Backpressure: in_ready decoded from registered state only (low when both entries held).
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   flush                synchronous discard of all held entries (highest priority)
//   in_valid/in_data     upstream payload, accepted when in_ready is high
//   in_ready             stage can take a payload this cycle
//   out_valid/out_data   downstream payload; out_data is BUBBLE when not valid
//   out_ready            downstream accepts; low stalls the stage
//   level                number of held entries (0..2)
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                PAY_W  = DEF_PAY_W,
    parameter logic [PAY_W-1:0]  BUBBLE = PAY_W'(DEF_BUBBLE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [PAY_W-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [PAY_W-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       level
);

    state_e           state_q;
    state_e           state_d;
    logic [PAY_W-1:0] main_q;
    logic [PAY_W-1:0] skid_q;

    logic in_fire;
    logic out_fire;

    // Datapath controls produced by the output decode.
    logic main_ld_in;    // MAIN takes the incoming payload
    logic main_ld_skid;  // MAIN takes the older payload parked in SKID
    logic skid_ld_in;    // SKID parks the incoming payload behind MAIN

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            // Flush wins over any simultaneous accept or drain; a payload
            // accepted in the same cycle is dropped along with the rest.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d = TWO;
                    end else if (!in_fire && out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    // in_ready and out_valid depend on registered state alone, so there is
    // no combinational path from out_ready or in_valid to in_ready; this is
    // what lets stages be chained without a long ready chain.
    always_comb begin
        in_ready     = (state_q != TWO);
        out_valid    = (state_q != EMPTY);
        level        = state_level(state_q);

        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld_in   = 1'b0;

        if (!flush) begin
            unique case (state_q)
                EMPTY: begin
                    main_ld_in = in_fire;
                end
                ONE: begin
                    // Head leaves and a new payload arrives: it becomes head.
                    // Head stays: the newcomer waits behind it in SKID.
                    main_ld_in = in_fire &&  out_fire;
                    skid_ld_in = in_fire && !out_fire;
                end
                TWO: begin
                    main_ld_skid = out_fire;
                end
                default: begin
                    main_ld_in = 1'b0;
                end
            endcase
        end
    end

    assign in_fire  = in_valid  && in_ready;
    assign out_fire = out_valid && out_ready;

    // Downstream never sees stale MAIN contents while the stage is empty.
    assign out_data = out_valid ? main_q : BUBBLE;

    // ------------------------------------------------------------------
    // Payload registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= BUBBLE;
        end else if (main_ld_skid) begin
            main_q <= skid_q;
        end else if (main_ld_in) begin
            main_q <= in_data;
        end
    end

    // SKID contents only matter in TWO; it is written only when parking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= BUBBLE;
        end else if (skid_ld_in) begin
            skid_q <= in_data;
        end
    end

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: reset checks, a vector table,
// hand-written corner sequences and a randomized run against a queue model.
module tb_pipe_skid_stage;

    localparam int W = 96;
    localparam logic [W-1:0] BUB = {64'h0, 32'h0000_0013};

    localparam logic [W-1:0] PA = {64'h0000_0000_0000_1000, 32'hAAAA_0001};
    localparam logic [W-1:0] PB = {64'h0000_0000_0000_1004, 32'hBBBB_0002};
    localparam logic [W-1:0] PC = {64'h0000_0000_0000_1008, 32'hCCCC_0003};
    localparam logic [W-1:0] PD = {64'h0000_0000_0000_100C, 32'hDDDD_0004};
    localparam logic [W-1:0] PE = {64'hFFFF_0000_0000_2000, 32'hEEEE_0005};

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [1:0]   level;

    int checks;
    int errors;

    // Reference model: the stage is a FIFO of at most two payloads.
    logic [W-1:0] mq[$];

    pipe_skid_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare all outputs against the queue model.
    task automatic chk_model(input string tag);
        logic [W-1:0] exp_dat;
        exp_dat = (mq.size() > 0) ? mq[0] : BUB;
        chk({tag, ".level"},     W'(level),     W'(mq.size()));
        chk({tag, ".out_valid"}, W'(out_valid), W'(mq.size() > 0));
        chk({tag, ".in_ready"},  W'(in_ready),  W'(mq.size() < 2));
        chk({tag, ".out_data"},  out_data,      exp_dat);
    endtask

    // Called at a negedge: drive inputs, advance one clock, update the model,
    // then return at the next negedge with outputs settled.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
        logic m_in_fire;
        logic m_out_fire;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        m_in_fire  = v && (mq.size() < 2);
        m_out_fire = (mq.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (m_out_fire) void'(mq.pop_front());
            if (m_in_fire)  mq.push_back(d);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic [1:0]   lvl;
        logic         ovld;
        logic [W-1:0] odat;
        logic         irdy;
    } vec_t;

    localparam int NVEC = 16;
    vec_t tbl[NVEC];

    initial begin
        // Expected values are the outputs after the edge that applies the row.
        tbl[0]  = '{1'b1, PA, 1'b1, 1'b0, 2'd1, 1'b1, PA,  1'b1}; // stream
        tbl[1]  = '{1'b1, PB, 1'b1, 1'b0, 2'd1, 1'b1, PB,  1'b1};
        tbl[2]  = '{1'b1, PC, 1'b1, 1'b0, 2'd1, 1'b1, PC,  1'b1};
        tbl[3]  = '{1'b1, PD, 1'b1, 1'b0, 2'd1, 1'b1, PD,  1'b1};
        tbl[4]  = '{1'b0, PE, 1'b1, 1'b0, 2'd0, 1'b0, BUB, 1'b1}; // drain
        tbl[5]  = '{1'b1, PA, 1'b0, 1'b0, 2'd1, 1'b1, PA,  1'b1}; // stall fill
        tbl[6]  = '{1'b1, PB, 1'b0, 1'b0, 2'd2, 1'b1, PA,  1'b0};
        tbl[7]  = '{1'b1, PC, 1'b0, 1'b0, 2'd2, 1'b1, PA,  1'b0}; // C held upstream
        tbl[8]  = '{1'b1, PC, 1'b1, 1'b0, 2'd1, 1'b1, PB,  1'b1}; // A out, C refused
        tbl[9]  = '{1'b1, PC, 1'b1, 1'b0, 2'd1, 1'b1, PC,  1'b1}; // B out, C in
        tbl[10] = '{1'b0, PE, 1'b1, 1'b0, 2'd0, 1'b0, BUB, 1'b1};
        tbl[11] = '{1'b1, PA, 1'b0, 1'b0, 2'd1, 1'b1, PA,  1'b1};
        tbl[12] = '{1'b1, PB, 1'b0, 1'b0, 2'd2, 1'b1, PA,  1'b0};
        tbl[13] = '{1'b1, PE, 1'b0, 1'b1, 2'd0, 1'b0, BUB, 1'b1}; // flush at level 2
        tbl[14] = '{1'b1, PE, 1'b1, 1'b1, 2'd0, 1'b0, BUB, 1'b1}; // flush held, E dropped
        tbl[15] = '{1'b0, PE, 1'b1, 1'b0, 2'd0, 1'b0, BUB, 1'b1};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = PE;
        out_ready = 1'b1;

        // Reset held across edges with a payload offered.
        repeat (3) @(negedge clk);
        chk("rst.out_valid", W'(out_valid), W'(0));
        chk("rst.out_data",  out_data,      BUB);
        chk("rst.level",     W'(level),     W'(0));
        chk("rst.in_ready",  W'(in_ready),  W'(1));
        rst_n = 1'b1;

        // Vector table (first row: first payload after reset, 1-cycle latency).
        for (int i = 0; i < NVEC; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("vec%0d.level", i),     W'(level),     W'(tbl[i].lvl));
            chk($sformatf("vec%0d.out_valid", i), W'(out_valid), W'(tbl[i].ovld));
            chk($sformatf("vec%0d.out_data", i),  out_data,      tbl[i].odat);
            chk($sformatf("vec%0d.in_ready", i),  W'(in_ready),  W'(tbl[i].irdy));
        end
        chk_model("post_vec");

        // Simultaneous in/out fire at level 1 keeps level 1.
        cycle(1'b1, PD, 1'b1, 1'b0);
        chk_model("sim1");
        cycle(1'b1, PE, 1'b1, 1'b0);
        chk_model("sim2");
        chk("sim.level", W'(level), W'(1));
        chk("sim.data",  out_data,  PE);

        // Asynchronous reset pulse between edges at level 2.
        cycle(1'b1, PA, 1'b0, 1'b0);
        cycle(1'b1, PB, 1'b0, 1'b0);
        chk("pre_arst.level", W'(level), W'(2));
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", W'(out_valid), W'(0));
        chk("arst.out_data",  out_data,      BUB);
        chk("arst.level",     W'(level),     W'(0));
        chk("arst.in_ready",  W'(in_ready),  W'(1));
        #1 rst_n = 1'b1;
        mq.delete();
        cycle(1'b0, PE, 1'b1, 1'b0);
        chk_model("arst_idle");
        cycle(1'b1, PC, 1'b1, 1'b0);
        chk_model("arst_first");
        chk("arst_first.data", out_data, PC);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 800; n++) begin
            logic [W-1:0] d;
            d = {$urandom, $urandom, $urandom};
            cycle(($urandom_range(0, 3) != 0), d,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipe_skid_stage

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL provide parameter PAY_W, default 96, meaning payload width in bits (64-bit PC concatenated with 32-bit instruction).
REQ-002 The block SHALL provide parameter BUBBLE, PAY_W bits, default {64'h0, 32'h00000013}, meaning the payload driven whenever out_valid=0.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 The block SHALL have port flush, input, 1 bit, synchronous discard of all held entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit, upstream payload present.
REQ-007 The block SHALL have port in_data, input, PAY_W bits, upstream payload.
REQ-008 The block SHALL have port in_ready, output, 1 bit, stage can accept this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit, out_data is a real entry.
REQ-010 The block SHALL have port out_data, output, PAY_W bits, downstream payload.
REQ-011 The block SHALL have port out_ready, input, 1 bit, downstream accepts; low means downstream stall.
REQ-012 The block SHALL have port level, output, 2 bits, entries held (0..2).

Function
REQ-013 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-014 The block SHALL hold two registered entries, MAIN (drives out_data) and SKID, and preserve FIFO order.
REQ-015 State machine states SHALL be EMPTY, ONE and TWO, and level SHALL equal 0, 1 and 2 respectively.
REQ-016 In EMPTY, in_fire SHALL load MAIN and go to ONE; otherwise the block SHALL stay in EMPTY.
REQ-017 In ONE, in_fire with out_fire SHALL reload MAIN and stay in ONE.
REQ-018 In ONE, in_fire without out_fire SHALL load SKID and go to TWO.
REQ-019 In ONE, out_fire without in_fire SHALL go to EMPTY.
REQ-020 In TWO, out_fire SHALL move SKID into MAIN and go to ONE; without out_fire the block SHALL hold TWO.
REQ-021 in_ready SHALL be (state != TWO), decoded directly from registered state, with no combinational path from out_ready or in_valid.
REQ-022 out_valid SHALL be (state != EMPTY), and out_data SHALL be MAIN when out_valid=1, else BUBBLE.
REQ-023 Latency SHALL be 1 cycle: a payload accepted at edge N appears on out_data after edge N when the stage was EMPTY, or when it was ONE with out_fire.
REQ-024 Throughput SHALL be one payload per cycle with out_ready held high.
REQ-025 flush=1 at an edge SHALL force EMPTY regardless of in_fire/out_fire, discarding any payload accepted that cycle; the payload on out_data that cycle counts as consumed only if out_fire.
REQ-026 flush SHALL have priority over every other transition; flush held for several cycles SHALL keep the stage EMPTY with in_ready=1.
REQ-027 The payload SHALL be passed bit-exact with no width conversion; the SKID contents SHALL be don't-care when the state is not TWO.

Reset
REQ-028 While rst_n=0, the state SHALL be EMPTY, out_valid=0, out_data=BUBBLE, level=0, in_ready=1, and MAIN/SKID SHALL be cleared to BUBBLE.
REQ-029 Reset asserted mid-operation SHALL drop all held entries immediately (asynchronously), and the first edge after deassertion SHALL behave as EMPTY.

Structure
REQ-030 Package pipe_pkg SHALL hold the state enum (EMPTY/ONE/TWO) and the RV_NOP constant 32'h00000013 used to build BUBBLE.
REQ-031 The block SHALL be a single module with no sub-module; the fetch/decode/execute stage instances SHALL differ only by PAY_W/BUBBLE.

Verification
REQ-032 Scenario: rst_n low with in_valid=1 -> out_valid=0, out_data=BUBBLE, level=0, in_ready=1; after release, the first in_data=A appears one cycle later.
REQ-033 Scenario: stream A,B,C,D with out_ready=1 -> out_data shows A,B,C,D on consecutive cycles, level=1, in_ready never low.
REQ-034 Scenario: out_ready=0 while A,B are offered -> level=2, in_ready=0, C is held upstream; out_ready=1 -> outputs A,B,C in order with none lost or duplicated.
REQ-035 Scenario: level=2, then flush=1 with in_valid=1 (payload E) -> next cycle level=0, out_data=BUBBLE, E is never output.
REQ-036 Scenario: level=1 with in_fire and out_fire in the same cycle -> level stays 1 and the new payload appears next cycle.
REQ-037 Scenario: rst_n pulsed low at level=2 between edges -> outputs go to reset values immediately; no old payload appears afterwards.
